flag_unit: RTL and testbench
============================

# flag_unit

Parametrised successor to the 32-bit combinational zero detector. It computes the zero flag over a WIDTH-bit ALU result with a radix-4 reduction tree, pipelined by PIPE register levels. It also carries N, C and V alongside the result and retires all four into an architectural flag register. It sits between the ALU and branch/condition logic, and reports in-flight flag writers so the decoder can stall dependent branches.

## Interface
- WIDTH, default 32: result width; any value ≥ 4. The result is zero-padded to the next multiple of 4.
- PIPE, default 1: number of reduction levels followed by a register; legal range 0..(tree levels − 1).
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  ALU result valid this cycle.
- result  in  WIDTH  ALU result.
- carry_in  in  1  ALU carry-out.
- ovf_in  in  1  ALU signed overflow.
- set_flags  in  1  the operation updates flags (e.g. ADDS/SUBS/CMP).
- stall  in  1  hold all pipeline stages.
- flush  in  1  kill all in-flight operations.
- wr_flags  in  1  direct write of the flag register (exception restore / MSR).
- wr_data  in  4  {z,n,c,v} for the direct write.
- flag_z, flag_n, flag_c, flag_v  out  1 each  architectural flag register.
- out_valid  out  1  an operation retired from the pipe this cycle.
- out_zero  out  1  zero result of the retiring operation, qualified by out_valid.
- flags_pending  out  1  at least one in-flight registered stage holds valid & set_flags.

## Operation
- Tree level 0: NOR4 per group of 4 bits. Every later level: AND4, with missing inputs tied to 1, down to a single bit. For WIDTH=32 there are 3 levels (8 → 2 → 1).
- Levels 0..PIPE−1 end in a pipeline register. The valid, set_flags, N (result[WIDTH−1]), C and V sidebands ride in the same stages.
- The last stage feeds a retire point:
  - out_valid = stage valid.
  - The flag register loads {z,n,c,v} when valid & set_flags & !stall.
- When valid & !set_flags the operation retires with out_valid = 1, and the flag register is unchanged.
- stall = 1:
  - Every stage holds.
  - Nothing retires; out_valid is forced to 0.
  - New input is not captured.
- flush = 1:
  - All stage valid bits clear at the next edge. flush has priority over stall.
  - The flag register is unaffected, and the retiring operation in the flush cycle is still dropped.
- wr_flags = 1:
  - The flag register loads wr_data at the next edge.
  - This has priority over a simultaneous retiring update, which is discarded.
- flags_pending = OR over registered stages of (valid & set_flags). It is combinational from registers and always 0 when PIPE = 0.
- Reset values: all flags 0, all stage valid bits 0, out_valid 0, out_zero 0, flags_pending 0.
- Reset asserted mid-operation discards in-flight operations immediately; no partial retire.

## Timing
- Latency: input in cycle t retires (out_valid = 1) in cycle t+PIPE. The flag register shows the new value from cycle t+PIPE+1.
- PIPE = 0: fully combinational to the retire point; flags are visible the cycle after input.
- Throughput: one operation per cycle when stall = 0. There is no backpressure other than stall.
- Back-to-back flag writers: each retires in order; the last one wins.

## Structure
- Package flag_pkg:
  - typedef struct packed {z, n, c, v} flags_t.
  - Index constants FLAG_Z=3, FLAG_N=2, FLAG_C=1, FLAG_V=0.
  - Function tree_levels(WIDTH) = ceil(log4(ceil(WIDTH/4)))+1.
- Sub-module zero_reduce4: one tree level, parametrised on input count and on mode (NOR / AND), with 1-padding of unused AND inputs. flag_unit instantiates it once per level in a generate loop.

## Test plan
- WIDTH=32, PIPE=2, result=0, set_flags=1 at cycle 0 → out_valid at cycle 2; flags {z,n,c,v}=1000 at cycle 3; flags_pending=1 in cycles 1–2.
- result=0x8000_0001, carry_in=1, ovf_in=1, set_flags=1 → flags 0111. A following result=0 with set_flags=0 → flags remain 0111 and out_zero=1.
- Single-bit walk: result=1<<k for k=0..31, plus WIDTH=30 with bit 29 set → z=0 each time. WIDTH=30 with result=0 → z=1 (padding check).
- stall asserted for 3 cycles with 2 ops in flight → no retire during the stall; ops retire in order afterwards with correct z. flush together with stall → both killed, flags unchanged.
- wr_flags=1, wr_data=0101 in the same cycle a set_flags op retiring z=1 → flag register = 0101.
- reset_n low mid-pipe with 2 ops in flight → all outputs 0 immediately. No retire after reset_n is released until new input arrives.

Source files
------------

// File: rtl/flag_pkg.sv
// rtl/flag_pkg.sv - flag record type, flag bit indices and reduction-tree sizing helpers
package flag_pkg;

    typedef struct packed {
        logic z;
        logic n;
        logic c;
        logic v;
    } flags_t;

    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Width of the node vector entering a given tree level (level 0 sees the raw result).
    function automatic int level_width(input int width, input int level);
        int w;
        w = width;
        for (int i = 0; i < level; i++) begin
            w = (w + 3) / 4;
        end
        return w;
    endfunction

    // Bit offset of a level's node vector inside the flattened node bus.
    function automatic int level_offset(input int width, input int level);
        int off;
        off = 0;
        for (int i = 0; i < level; i++) begin
            off = off + level_width(width, i);
        end
        return off;
    endfunction

    function automatic int tree_levels(input int width);
        int n;
        int lv;
        n  = (width + 3) / 4;
        lv = 1;
        while (n > 1) begin
            n  = (n + 3) / 4;
            lv = lv + 1;
        end
        return lv;
    endfunction

endpackage

// File: rtl/zero_reduce4.sv
// rtl/zero_reduce4.sv - one radix-4 level of the zero-detect tree (NOR4 leaf or AND4 interior)
module zero_reduce4 #(
    parameter int N_IN     = 32,
    parameter bit NOR_MODE = 1'b1
) (
    input  logic [N_IN-1:0]         din,
    output logic [(N_IN+3)/4-1:0]   dout
);

    localparam int N_OUT = (N_IN + 3) / 4;
    localparam int N_PAD = N_OUT * 4;

    logic [N_PAD-1:0] padded;

    // Leaf padding is 0 (result zero-extension); interior padding is 1 so AND is unaffected.
    if (N_PAD > N_IN) begin : g_pad
        assign padded = {{(N_PAD - N_IN){~NOR_MODE}}, din};
    end else begin : g_nopad
        assign padded = din;
    end

    for (genvar g = 0; g < N_OUT; g++) begin : g_grp
        if (NOR_MODE) begin : g_nor
            assign dout[g] = ~|padded[4*g +: 4];
        end else begin : g_and
            assign dout[g] = &padded[4*g +: 4];
        end
    end

endmodule

// File: rtl/flag_unit.sv
// rtl/flag_unit.sv - pipelined zero-flag tree with N/C/V sidebands and architectural flag register
module flag_unit
    import flag_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int PIPE  = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] result,
    input  logic             carry_in,
    input  logic             ovf_in,
    input  logic             set_flags,
    input  logic             stall,
    input  logic             flush,
    input  logic             wr_flags,
    input  logic [3:0]       wr_data,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v,
    output logic             out_valid,
    output logic             out_zero,
    output logic             flags_pending
);

    localparam int LEVELS    = tree_levels(WIDTH);
    localparam int NODE_BITS = level_offset(WIDTH, LEVELS + 1);
    localparam int Z_OFF     = level_offset(WIDTH, LEVELS);

    // Node vectors of every level packed back to back; slot l feeds tree level l.
    logic [NODE_BITS-1:0] node;
    logic [LEVELS:0]      vld;
    logic [LEVELS:0]      sfl;
    logic [LEVELS:0]      nfl;
    logic [LEVELS:0]      cfl;
    logic [LEVELS:0]      ofl;
    logic [LEVELS-1:0]    pend;

    assign node[0 +: WIDTH] = result;
    assign vld[0] = in_valid;
    assign sfl[0] = set_flags;
    assign nfl[0] = result[WIDTH-1];
    assign cfl[0] = carry_in;
    assign ofl[0] = ovf_in;

    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        localparam int W_IN    = level_width(WIDTH, l);
        localparam int W_OUT   = level_width(WIDTH, l + 1);
        localparam int OFF_IN  = level_offset(WIDTH, l);
        localparam int OFF_OUT = level_offset(WIDTH, l + 1);

        logic [W_OUT-1:0] red;

        zero_reduce4 #(
            .N_IN     (W_IN),
            .NOR_MODE (l == 0)
        ) u_red (
            .din  (node[OFF_IN +: W_IN]),
            .dout (red)
        );

        if (l < PIPE) begin : g_reg
            logic [W_OUT-1:0] d_q;
            logic             v_q;
            logic             sf_q;
            logic             n_q;
            logic             c_q;
            logic             o_q;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    d_q  <= '0;
                    v_q  <= 1'b0;
                    sf_q <= 1'b0;
                    n_q  <= 1'b0;
                    c_q  <= 1'b0;
                    o_q  <= 1'b0;
                end else begin
                    if (flush) begin
                        v_q <= 1'b0;
                    end else if (!stall) begin
                        v_q <= vld[l];
                    end
                    if (!stall) begin
                        d_q  <= red;
                        sf_q <= sfl[l];
                        n_q  <= nfl[l];
                        c_q  <= cfl[l];
                        o_q  <= ofl[l];
                    end
                end
            end

            assign node[OFF_OUT +: W_OUT] = d_q;
            assign vld[l+1] = v_q;
            assign sfl[l+1] = sf_q;
            assign nfl[l+1] = n_q;
            assign cfl[l+1] = c_q;
            assign ofl[l+1] = o_q;
            assign pend[l]  = v_q & sf_q;
        end else begin : g_comb
            assign node[OFF_OUT +: W_OUT] = red;
            assign vld[l+1] = vld[l];
            assign sfl[l+1] = sfl[l];
            assign nfl[l+1] = nfl[l];
            assign cfl[l+1] = cfl[l];
            assign ofl[l+1] = ofl[l];
            assign pend[l]  = 1'b0;
        end
    end

    logic   retire;
    logic   z_ret;
    flags_t flags_q;
    flags_t flags_new;

    // A retiring op is dropped while stalled or flushed, so out_valid and flag load share one qualifier.
    assign retire    = vld[LEVELS] & ~stall & ~flush;
    assign z_ret     = node[Z_OFF];
    assign flags_new = '{z: z_ret, n: nfl[LEVELS], c: cfl[LEVELS], v: ofl[LEVELS]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flags_q <= '0;
        end else if (wr_flags) begin
            flags_q <= flags_t'(wr_data);
        end else if (retire && sfl[LEVELS]) begin
            flags_q <= flags_new;
        end
    end

    assign out_valid     = retire;
    assign out_zero      = retire & z_ret;
    assign flags_pending = |pend;
    assign flag_z        = flags_q.z;
    assign flag_n        = flags_q.n;
    assign flag_c        = flags_q.c;
    assign flag_v        = flags_q.v;

endmodule

// File: tb/tb_flag_unit.sv
// tb/tb_flag_unit.sv - directed self-checking bench for flag_unit (32-bit/PIPE=2 and 30-bit/PIPE=0)
module tb_flag_unit;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic [31:0] result;
    logic [29:0] result30;
    logic        carry_in;
    logic        ovf_in;
    logic        set_flags;
    logic        stall;
    logic        flush;
    logic        wr_flags;
    logic [3:0]  wr_data;

    logic fz, fn, fc, fv, ov, oz, pend;
    logic fz30, fn30, fc30, fv30, ov30, oz30, pend30;
    logic [3:0] fl;
    logic [3:0] fl30;

    int n_checks;
    int n_errors;

    assign fl   = {fz, fn, fc, fv};
    assign fl30 = {fz30, fn30, fc30, fv30};

    flag_unit #(.WIDTH(32), .PIPE(2)) u_dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .in_valid      (in_valid),
        .result        (result),
        .carry_in      (carry_in),
        .ovf_in        (ovf_in),
        .set_flags     (set_flags),
        .stall         (stall),
        .flush         (flush),
        .wr_flags      (wr_flags),
        .wr_data       (wr_data),
        .flag_z        (fz),
        .flag_n        (fn),
        .flag_c        (fc),
        .flag_v        (fv),
        .out_valid     (ov),
        .out_zero      (oz),
        .flags_pending (pend)
    );

    flag_unit #(.WIDTH(30), .PIPE(0)) u_dut30 (
        .clk           (clk),
        .reset_n       (reset_n),
        .in_valid      (in_valid),
        .result        (result30),
        .carry_in      (carry_in),
        .ovf_in        (ovf_in),
        .set_flags     (set_flags),
        .stall         (stall),
        .flush         (flush),
        .wr_flags      (wr_flags),
        .wr_data       (wr_data),
        .flag_z        (fz30),
        .flag_n        (fn30),
        .flag_c        (fc30),
        .flag_v        (fv30),
        .out_valid     (ov30),
        .out_zero      (oz30),
        .flags_pending (pend30)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] r, input logic c, input logic o, input logic sf);
        in_valid  = v;
        result    = r;
        result30  = r[29:0];
        carry_in  = c;
        ovf_in    = o;
        set_flags = sf;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] r;
        n_checks = 0;
        n_errors = 0;
        reset_n  = 1'b0;
        stall    = 1'b0;
        flush    = 1'b0;
        wr_flags = 1'b0;
        wr_data  = 4'h0;
        idle();
        #2;
        check("rst_out_valid", ov, 0);
        check("rst_out_zero", oz, 0);
        check("rst_pending", pend, 0);
        check("rst_flags", fl, 4'b0000);
        cyc();
        cyc();
        reset_n = 1'b1;
        cyc();

        // zero result through PIPE=2: retire at t+2, flags at t+3
        drive(1'b1, 32'h0, 1'b0, 1'b0, 1'b1);
        cyc();
        idle();
        #1;
        check("t1_c1_pending", pend, 1);
        check("t1_c1_out_valid", ov, 0);
        cyc();
        check("t1_c2_out_valid", ov, 1);
        check("t1_c2_out_zero", oz, 1);
        check("t1_c2_pending", pend, 1);
        check("t1_c2_flags_old", fl, 4'b0000);
        cyc();
        check("t1_c3_flags", fl, 4'b1000);
        check("t1_c3_pending", pend, 0);
        check("t1_c3_out_valid", ov, 0);

        // N/C/V capture, then a non-flag-setting zero op
        drive(1'b1, 32'h8000_0001, 1'b1, 1'b1, 1'b1);
        cyc();
        drive(1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
        cyc();
        idle();
        #1;
        check("t2_op1_out_valid", ov, 1);
        check("t2_op1_out_zero", oz, 0);
        cyc();
        check("t2_op2_out_valid", ov, 1);
        check("t2_op2_out_zero", oz, 1);
        check("t2_op1_flags", fl, 4'b0111);
        cyc();
        check("t2_flags_kept", fl, 4'b0111);
        check("t2_idle_out_valid", ov, 0);

        // single-bit walk on both widths
        for (int k = 0; k < 32; k++) begin
            r = 32'd1 << k;
            drive(1'b1, r, 1'b0, 1'b0, 1'b1);
            result30 = 30'd1 << (k % 30);
            #1;
            check($sformatf("walk30_valid_%0d", k), ov30, 1);
            check($sformatf("walk30_zero_%0d", k), oz30, 0);
            cyc();
            idle();
            cyc();
            check($sformatf("walk_valid_%0d", k), ov, 1);
            check($sformatf("walk_zero_%0d", k), oz, 0);
            cyc();
            check($sformatf("walk_flag_z_%0d", k), fz, 0);
        end
        check("walk_last_flags", fl, 4'b0100);

        // 30-bit: bit 29 is the sign; zero result exercises the padded group
        drive(1'b1, 32'h2000_0000, 1'b0, 1'b0, 1'b1);
        cyc();
        check("w30_b29_flags", fl30, 4'b0100);
        drive(1'b1, 32'h0, 1'b0, 1'b0, 1'b1);
        #1;
        check("w30_zero_out", oz30, 1);
        cyc();
        idle();
        check("w30_zero_flags", fl30, 4'b1000);
        cyc();
        cyc();
        cyc();

        // stall for 3 cycles with two ops in flight
        drive(1'b1, 32'h0, 1'b0, 1'b0, 1'b1);
        cyc();
        drive(1'b1, 32'h5, 1'b1, 1'b0, 1'b1);
        cyc();
        idle();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("stall_out_valid_%0d", i), ov, 0);
            check($sformatf("stall_pending_%0d", i), pend, 1);
            cyc();
        end
        stall = 1'b0;
        #1;
        check("stall_a_valid", ov, 1);
        check("stall_a_zero", oz, 1);
        cyc();
        check("stall_a_flags", fl, 4'b1000);
        check("stall_b_valid", ov, 1);
        check("stall_b_zero", oz, 0);
        cyc();
        check("stall_b_flags", fl, 4'b0010);
        check("stall_done_valid", ov, 0);

        // flush together with stall kills both in-flight ops
        drive(1'b1, 32'h0, 1'b1, 1'b1, 1'b1);
        cyc();
        drive(1'b1, 32'h0, 1'b0, 1'b0, 1'b1);
        cyc();
        idle();
        stall = 1'b1;
        flush = 1'b1;
        #1;
        check("flush_out_valid", ov, 0);
        cyc();
        stall = 1'b0;
        flush = 1'b0;
        #1;
        check("flush_pending", pend, 0);
        check("flush_after_valid0", ov, 0);
        cyc();
        check("flush_after_valid1", ov, 0);
        check("flush_flags", fl, 4'b0010);

        // direct write wins over a retiring update
        drive(1'b1, 32'h0, 1'b0, 1'b0, 1'b1);
        cyc();
        idle();
        cyc();
        wr_flags = 1'b1;
        wr_data  = 4'b0101;
        #1;
        check("wr_retire_valid", ov, 1);
        check("wr_retire_zero", oz, 1);
        cyc();
        wr_flags = 1'b0;
        wr_data  = 4'b0000;
        check("wr_flags_win", fl, 4'b0101);
        cyc();
        check("wr_flags_hold", fl, 4'b0101);

        // async reset with two ops in flight
        drive(1'b1, 32'h0, 1'b1, 1'b0, 1'b1);
        cyc();
        drive(1'b1, 32'h0, 1'b0, 1'b1, 1'b1);
        cyc();
        idle();
        check("rst_mid_pending_pre", pend, 1);
        reset_n = 1'b0;
        #1;
        check("rst_mid_out_valid", ov, 0);
        check("rst_mid_out_zero", oz, 0);
        check("rst_mid_pending", pend, 0);
        check("rst_mid_flags", fl, 4'b0000);
        cyc();
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            check($sformatf("rst_post_valid_%0d", i), ov, 0);
            check($sformatf("rst_post_flags_%0d", i), fl, 4'b0000);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
